// File: rtl/fix_session_ctrl_if.sv
// Command channel from the session scheduler to the downstream connect fifo.
// The fifo drives fifo_ready_i; the scheduler drives the command strobes.
interface fix_session_ctrl_if #(
    parameter int HOST_W = 2
);
    logic              fifo_ready_i;
    logic              connect_req_o;
    logic [HOST_W-1:0] connect_addr_o;
    logic              disconnect_o;
    logic [HOST_W-1:0] disconnect_host_num_o;

    modport master (
        input  fifo_ready_i,
        output connect_req_o,
        output connect_addr_o,
        output disconnect_o,
        output disconnect_host_num_o
    );

    modport slave (
        output fifo_ready_i,
        input  connect_req_o,
        input  connect_addr_o,
        input  disconnect_o,
        input  disconnect_host_num_o
    );
endinterface

// File: rtl/fix_session_ctrl.sv
// Round-robin connect/disconnect scheduler with connect timeout and retry.
// Optional per-host idle disconnect: define HEARTBEAT_TIMEOUT_EN.
module fix_session_ctrl #(
    parameter int HOST_W       = 2,
    parameter int CONN_TIMEOUT = 16,
    parameter int MAX_RETRY    = 2,
    parameter int HB_TIMEOUT   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     connect_i,
    input  logic [HOST_W-1:0]        connect_to_host_i,
    input  logic                     disconnect_i,
    input  logic [HOST_W-1:0]        disconnect_host_i,
    input  logic                     connected_i,
    input  logic [HOST_W-1:0]        connected_host_addr_i,
    input  logic                     rx_valid_i,
    input  logic [HOST_W-1:0]        rx_host_i,
    fix_session_ctrl_if.master       cmd,
    output logic [(1<<HOST_W)-1:0]   host_connected_o,
    output logic                     connect_fail_o,
    output logic                     hb_expired_o,
    output logic                     busy_o
);
    localparam int NUM_HOSTS = 1 << HOST_W;
    localparam int TMR_W     = $clog2(CONN_TIMEOUT);
    localparam int RTY_W     = $clog2(MAX_RETRY + 2);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CONN_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISC
    } state_t;

    state_t                 r_state;
    logic [HOST_W-1:0]      r_target;
    logic [HOST_W-1:0]      r_last;
    logic [TMR_W-1:0]       r_timer;
    logic [RTY_W-1:0]       r_retry;
    logic [NUM_HOSTS-1:0]   r_conn_pend;
    logic [NUM_HOSTS-1:0]   r_disc_pend;
    logic [NUM_HOSTS-1:0]   r_connected;
    logic                   r_fail;

    logic                   r_c_v;
    logic [HOST_W-1:0]      r_c_h;
    logic                   r_d_v;
    logic [HOST_W-1:0]      r_d_h;

    logic                   w_c_set;
    logic                   w_d_set;
    logic                   w_target_busy;
    logic [NUM_HOSTS-1:0]   w_cset;
    logic [NUM_HOSTS-1:0]   w_dset;
    logic [NUM_HOSTS-1:0]   w_hb_set;
    logic                   w_ack;
    logic                   w_tmo;
    logic                   w_disc_hit;
    logic [HOST_W-1:0]      w_disc_sel;
    logic                   w_conn_hit;
    logic [HOST_W-1:0]      w_conn_sel;
    logic [HOST_W-1:0]      w_idx;

    // App strobes are registered first; bitmaps update one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_v <= 1'b0;
            r_c_h <= '0;
            r_d_v <= 1'b0;
            r_d_h <= '0;
        end else begin
            r_c_v <= connect_i;
            r_c_h <= connect_to_host_i;
            r_d_v <= disconnect_i;
            r_d_h <= disconnect_host_i;
        end
    end

    assign w_target_busy = (r_state != S_IDLE) && (r_target == r_c_h);
    assign w_c_set = r_c_v && !r_connected[r_c_h] && !r_conn_pend[r_c_h]
                   && !w_target_busy && !(r_d_v && (r_d_h == r_c_h));
    assign w_d_set = r_d_v && r_connected[r_d_h];
    assign w_cset  = w_c_set ? (NUM_HOSTS'(1) << r_c_h) : '0;
    assign w_dset  = (w_d_set ? (NUM_HOSTS'(1) << r_d_h) : '0) | w_hb_set;

    assign w_ack = (r_state == S_WAIT) && connected_i
                 && (connected_host_addr_i == r_target);
    assign w_tmo = (r_state == S_WAIT) && (r_timer == TMR_LAST);

    // Search starts at last_served+1; last_served itself is the final candidate.
    always_comb begin
        w_disc_hit = 1'b0;
        w_disc_sel = r_last;
        w_conn_hit = 1'b0;
        w_conn_sel = r_last;
        w_idx      = r_last;
        for (int i = 1; i <= NUM_HOSTS; i++) begin
            w_idx = r_last + HOST_W'(i);
            if (!w_disc_hit && r_disc_pend[w_idx]) begin
                w_disc_hit = 1'b1;
                w_disc_sel = w_idx;
            end
            if (!w_conn_hit && r_conn_pend[w_idx]) begin
                w_conn_hit = 1'b1;
                w_conn_sel = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_target    <= '0;
            r_last      <= '0;
            r_timer     <= '0;
            r_retry     <= '0;
            r_conn_pend <= '0;
            r_disc_pend <= '0;
            r_connected <= '0;
            r_fail      <= 1'b0;
        end else begin
            r_fail      <= 1'b0;
            r_conn_pend <= r_conn_pend | w_cset;
            r_disc_pend <= r_disc_pend | w_dset;
            unique case (r_state)
                S_IDLE: begin
                    if (w_disc_hit) begin
                        r_state  <= S_DISC;
                        r_target <= w_disc_sel;
                        r_last   <= w_disc_sel;
                    end else if (w_conn_hit) begin
                        r_state  <= S_REQ;
                        r_target <= w_conn_sel;
                        r_last   <= w_conn_sel;
                    end
                end
                S_REQ: begin
                    if (cmd.fifo_ready_i) begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // An ack on the expiry cycle still wins.
                    if (w_ack) begin
                        r_connected[r_target] <= 1'b1;
                        r_conn_pend[r_target] <= 1'b0;
                        r_retry               <= '0;
                        r_state               <= S_IDLE;
                    end else if (w_tmo) begin
                        if (r_retry < RTY_MAX) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= S_REQ;
                        end else begin
                            r_fail                <= 1'b1;
                            r_conn_pend[r_target] <= 1'b0;
                            r_retry               <= '0;
                            r_state               <= S_IDLE;
                        end
                    end
                end
                S_DISC: begin
                    if (cmd.fifo_ready_i) begin
                        r_connected[r_target] <= 1'b0;
                        r_disc_pend[r_target] <= 1'b0;
                        r_state               <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HEARTBEAT_TIMEOUT_EN
    localparam int HB_W = $clog2(HB_TIMEOUT);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_TIMEOUT - 1);
    localparam logic [HB_W-1:0] HB_PRE  = HB_W'(HB_TIMEOUT - 2);

    logic [HB_W-1:0]        r_hb_cnt [NUM_HOSTS];
    logic                   r_hb_exp;
    logic [NUM_HOSTS-1:0]   w_rx_hit;
    logic [NUM_HOSTS-1:0]   w_hb_exp;

    always_comb begin
        w_rx_hit = '0;
        w_hb_exp = '0;
        for (int h = 0; h < NUM_HOSTS; h++) begin
            w_rx_hit[h] = rx_valid_i && (rx_host_i == HOST_W'(h));
            w_hb_exp[h] = r_connected[h] && !w_rx_hit[h]
                        && (r_hb_cnt[h] == HB_PRE);
        end
    end

    // Counter freezes at its last value until the host is disconnected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int h = 0; h < NUM_HOSTS; h++) r_hb_cnt[h] <= '0;
            r_hb_exp <= 1'b0;
        end else begin
            r_hb_exp <= |w_hb_exp;
            for (int h = 0; h < NUM_HOSTS; h++) begin
                if (!r_connected[h]) r_hb_cnt[h] <= '0;
                else if (r_hb_cnt[h] == HB_LAST) r_hb_cnt[h] <= HB_LAST;
                else if (w_rx_hit[h]) r_hb_cnt[h] <= '0;
                else r_hb_cnt[h] <= r_hb_cnt[h] + 1'b1;
            end
        end
    end

    assign w_hb_set     = w_hb_exp;
    assign hb_expired_o = r_hb_exp;
`else
    logic w_unused;
    assign w_unused     = ^{rx_valid_i, rx_host_i};
    assign w_hb_set     = '0;
    assign hb_expired_o = 1'b0;
`endif

    assign cmd.connect_req_o         = (r_state == S_REQ) && cmd.fifo_ready_i;
    assign cmd.connect_addr_o        = r_target;
    assign cmd.disconnect_o          = (r_state == S_DISC) && cmd.fifo_ready_i;
    assign cmd.disconnect_host_num_o = r_target;
    assign host_connected_o          = r_connected;
    assign connect_fail_o            = r_fail;
    assign busy_o = (r_state != S_IDLE) || (|r_conn_pend) || (|r_disc_pend);

endmodule
